// File: rtl/lmul_issue_ctrl.sv
// Purpose: sequences BF16 operand pairs through one LMUL unit, one start outstanding at a time.
// Latency: operand handshake -> start 1 cycle; result valid 1 cycle after lmul_ready is seen in WAIT.
// Backpressure: res_ready low holds the result in EMIT; no new operand is fetched until it drains.
//
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   cmd_valid/cmd_ready/cmd_len      batch command (number of pairs, 0 allowed)
//   op_valid/op_ready/op_a/op_b      operand pair stream
//   lmul_start/lmul_a/lmul_b         request to the LMUL unit (operands held until result capture)
//   lmul_ready/lmul_out              unit result level and 32-bit result (product in [31:16])
//   res_valid/res_ready/res_data/res_last  BF16 product stream
//   busy, err_timeout                status; err_timeout is sticky until reset or next command
module lmul_issue_ctrl #(
    parameter int LEN_W   = 8,
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [15:0]      op_a,
    input  logic [15:0]      op_b,
    output logic             lmul_start,
    output logic [15:0]      lmul_a,
    output logic [15:0]      lmul_b,
    input  logic             lmul_ready,
    input  logic [31:0]      lmul_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [15:0]      res_data,
    output logic             res_last,
    output logic             busy,
    output logic             err_timeout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_WAIT,
        S_EMIT
    } state_t;

    localparam logic [CNT_W-1:0] TMO_LOAD = CNT_W'(TIMEOUT);
    localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);

    state_t           state, state_nxt;
    logic [LEN_W-1:0] remaining, remaining_nxt;
    logic [CNT_W-1:0] tmo_cnt, tmo_cnt_nxt;
    logic [15:0]      lmul_a_nxt, lmul_b_nxt, res_data_nxt;
    logic             res_last_nxt, err_timeout_nxt;

    // The unit drives zeros in the low half; only the product half is used.
    logic unused_lmul_lo;
    assign unused_lmul_lo = ^lmul_out[15:0];

    // Handshake and status outputs are pure state decodes.
    assign cmd_ready  = (state == S_IDLE);
    assign op_ready   = (state == S_FETCH);
    assign lmul_start = (state == S_ISSUE);
    assign res_valid  = (state == S_EMIT);
    assign busy       = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            remaining   <= '0;
            tmo_cnt     <= '0;
            lmul_a      <= '0;
            lmul_b      <= '0;
            res_data    <= '0;
            res_last    <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            state       <= state_nxt;
            remaining   <= remaining_nxt;
            tmo_cnt     <= tmo_cnt_nxt;
            lmul_a      <= lmul_a_nxt;
            lmul_b      <= lmul_b_nxt;
            res_data    <= res_data_nxt;
            res_last    <= res_last_nxt;
            err_timeout <= err_timeout_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        remaining_nxt   = remaining;
        tmo_cnt_nxt     = tmo_cnt;
        lmul_a_nxt      = lmul_a;
        lmul_b_nxt      = lmul_b;
        res_data_nxt    = res_data;
        res_last_nxt    = res_last;
        err_timeout_nxt = err_timeout;

        unique case (state)
            S_IDLE: begin
                if (cmd_valid) begin
                    remaining_nxt   = cmd_len;
                    err_timeout_nxt = 1'b0;
                    if (cmd_len != '0) begin
                        state_nxt = S_FETCH;
                    end
                end
            end
            S_FETCH: begin
                if (op_valid) begin
                    lmul_a_nxt = op_a;
                    lmul_b_nxt = op_b;
                    state_nxt  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // lmul_ready here still reflects the previous operation, so it is not looked at.
                tmo_cnt_nxt = TMO_LOAD;
                state_nxt   = S_WAIT;
            end
            S_WAIT: begin
                if (lmul_ready) begin
                    res_data_nxt = lmul_out[31:16];
                    res_last_nxt = (remaining == LEN_ONE);
                    state_nxt    = S_EMIT;
                end else if (tmo_cnt == '0) begin
                    // Abandon the whole batch; the unit is considered dead.
                    err_timeout_nxt = 1'b1;
                    remaining_nxt   = '0;
                    state_nxt       = S_IDLE;
                end else begin
                    tmo_cnt_nxt = tmo_cnt - CNT_W'(1);
                end
            end
            S_EMIT: begin
                if (res_ready) begin
                    res_last_nxt  = 1'b0;
                    remaining_nxt = remaining - LEN_ONE;
                    state_nxt     = (remaining == LEN_ONE) ? S_IDLE : S_FETCH;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_lmul_issue_ctrl.sv
module tb_lmul_issue_ctrl;

    localparam int LEN_W   = 8;
    localparam int TIMEOUT = 15;
    localparam int CNT_W   = 4;
    localparam int LAT     = 5;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [LEN_W-1:0] cmd_len = '0;
    logic             op_valid = 1'b0;
    logic             op_ready;
    logic [15:0]      op_a = '0;
    logic [15:0]      op_b = '0;
    logic             lmul_start;
    logic [15:0]      lmul_a;
    logic [15:0]      lmul_b;
    logic             lmul_ready;
    logic [31:0]      lmul_out;
    logic             res_valid;
    logic             res_ready = 1'b1;
    logic [15:0]      res_data;
    logic             res_last;
    logic             busy;
    logic             err_timeout;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    lmul_issue_ctrl #(.LEN_W(LEN_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
        .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
        .lmul_start(lmul_start), .lmul_a(lmul_a), .lmul_b(lmul_b),
        .lmul_ready(lmul_ready), .lmul_out(lmul_out),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_last(res_last),
        .busy(busy), .err_timeout(err_timeout)
    );

    // LMUL stand-in: hand-computed BF16 products for the operand pairs used below.
    function automatic logic [15:0] bf16_prod(input logic [15:0] a, input logic [15:0] b);
        logic [31:0] key;
        key = {a, b};
        case (key)
            32'h3F80_3F80: return 16'h3F80;  //  1 *  1 =  1
            32'h4000_4000: return 16'h4080;  //  2 *  2 =  4
            32'hBF80_4000: return 16'hC000;  // -1 *  2 = -2
            32'h0000_3F80: return 16'h0000;  //  0 *  1 =  0
            default:       return 16'hDEAD;
        endcase
    endfunction

    logic        stub_dead = 1'b0;
    int          stub_cnt;
    logic [15:0] stub_prod;
    int          start_pulses;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stub_cnt   <= 0;
            stub_prod  <= '0;
            lmul_ready <= 1'b0;
            lmul_out   <= '0;
        end else if (lmul_start) begin
            lmul_ready <= 1'b0;
            stub_cnt   <= LAT;
            stub_prod  <= bf16_prod(lmul_a, lmul_b);
        end else if (stub_cnt != 0) begin
            stub_cnt <= stub_cnt - 1;
            if (stub_cnt == 1 && !stub_dead) begin
                lmul_ready <= 1'b1;
                lmul_out   <= {stub_prod, 16'h0000};
            end
        end
    end

    // Start pulses are counted across resets so that a stray start after reset is visible.
    initial start_pulses = 0;
    always @(posedge clk) begin
        if (lmul_start) start_pulses <= start_pulses + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_cmd(input logic [LEN_W-1:0] len);
        chk("cmd_ready_before_cmd", {31'b0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1;
        cmd_len   = len;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic send_op(input logic [15:0] a, input logic [15:0] b);
        logic ok;
        ok = 1'b0;
        op_valid = 1'b1;
        op_a = a;
        op_b = b;
        for (int i = 0; i < 60; i++) begin
            if (op_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("op_handshake", {31'b0, ok}, 32'd1);
        @(negedge clk);
        op_valid = 1'b0;
    endtask

    // Waits for a result with res_ready high, checks it, then steps past the handshake.
    task automatic get_res(input string tag, input logic [15:0] exp_d, input logic exp_l, output int cyc);
        cyc = 0;
        while (!res_valid && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_valid"}, {31'b0, res_valid}, 32'd1);
        chk({tag, "_data"}, {16'b0, res_data}, {16'b0, exp_d});
        chk({tag, "_last"}, {31'b0, res_last}, {31'b0, exp_l});
        @(negedge clk);
    endtask

    initial begin
        int   cyc;
        int   s0;
        logic stable;
        logic seen;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        chk("rst_op_ready", {31'b0, op_ready}, 32'd0);
        chk("rst_lmul_start", {31'b0, lmul_start}, 32'd0);
        chk("rst_lmul_ab", {lmul_a, lmul_b}, 32'd0);
        chk("rst_res", {14'b0, res_valid, res_last, res_data}, 32'd0);
        chk("rst_status", {30'b0, busy, err_timeout}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single pair 1.0 * 1.0
        s0 = start_pulses;
        send_cmd(8'd1);
        send_op(16'h3F80, 16'h3F80);
        chk("t1_issue_start", {31'b0, lmul_start}, 32'd1);
        chk("t1_issue_ops", {lmul_a, lmul_b}, 32'h3F80_3F80);
        get_res("t1", 16'h3F80, 1'b1, cyc);
        chk("t1_latency", cyc, 32'd7);
        chk("t1_busy_after", {31'b0, busy}, 32'd0);
        chk("t1_starts", start_pulses - s0, 32'd1);

        // Three-pair batch
        s0 = start_pulses;
        send_cmd(8'd3);
        send_op(16'h4000, 16'h4000);
        get_res("t2a", 16'h4080, 1'b0, cyc);
        send_op(16'hBF80, 16'h4000);
        get_res("t2b", 16'hC000, 1'b0, cyc);
        send_op(16'h0000, 16'h3F80);
        get_res("t2c", 16'h0000, 1'b1, cyc);
        chk("t2_starts", start_pulses - s0, 32'd3);
        chk("t2_idle", {31'b0, cmd_ready}, 32'd1);

        // Backpressure on first result of a 2-pair batch
        s0 = start_pulses;
        res_ready = 1'b0;
        send_cmd(8'd2);
        send_op(16'h4000, 16'h4000);
        cyc = 0;
        while (!res_valid && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("t3_valid", {31'b0, res_valid}, 32'd1);
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (!res_valid || res_data !== 16'h4080 || op_ready || lmul_start || res_last)
                stable = 1'b0;
            @(negedge clk);
        end
        chk("t3_stable", {31'b0, stable}, 32'd1);
        chk("t3_starts_held", start_pulses - s0, 32'd1);
        res_ready = 1'b1;
        @(negedge clk);
        chk("t3_drain_fetch", {30'b0, res_valid, op_ready}, 32'd1);
        send_op(16'hBF80, 16'h4000);
        get_res("t3b", 16'hC000, 1'b1, cyc);
        chk("t3_starts", start_pulses - s0, 32'd2);

        // Unit never answers
        stub_dead = 1'b1;
        send_cmd(8'd1);
        send_op(16'h4000, 16'h4000);
        repeat (10) @(negedge clk);
        chk("t4_err_early", {30'b0, busy, err_timeout}, 32'd2);
        seen = 1'b0;
        cyc = 0;
        while (!err_timeout && cyc < 40) begin
            if (res_valid) seen = 1'b1;
            @(negedge clk);
            cyc++;
        end
        chk("t4_err_set", {31'b0, err_timeout}, 32'd1);
        chk("t4_no_result", {31'b0, seen | res_valid}, 32'd0);
        chk("t4_idle", {30'b0, busy, cmd_ready}, 32'd1);
        stub_dead = 1'b0;
        send_cmd(8'd1);
        chk("t4_err_cleared", {31'b0, err_timeout}, 32'd0);
        send_op(16'h3F80, 16'h3F80);
        get_res("t4r", 16'h3F80, 1'b1, cyc);

        // Zero-length command
        s0 = start_pulses;
        send_cmd(8'd0);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (op_ready || lmul_start || res_valid || !cmd_ready || busy) seen = 1'b1;
            @(negedge clk);
        end
        chk("t5_quiet", {31'b0, seen}, 32'd0);
        chk("t5_starts", start_pulses - s0, 32'd0);

        // Reset during WAIT of pair 2 of 4
        send_cmd(8'd4);
        send_op(16'h4000, 16'h4000);
        get_res("t6a", 16'h4080, 1'b0, cyc);
        send_op(16'hBF80, 16'h4000);
        repeat (3) @(negedge clk);
        chk("t6_in_wait", {31'b0, busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_hs", {29'b0, cmd_ready, op_ready, lmul_start}, 32'h4);
        chk("t6_rst_ab", {lmul_a, lmul_b}, 32'd0);
        chk("t6_rst_res", {14'b0, res_valid, res_last, res_data}, 32'd0);
        chk("t6_rst_status", {30'b0, busy, err_timeout}, 32'd0);
        s0 = start_pulses;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("t6_no_start", start_pulses - s0, 32'd0);
        s0 = start_pulses;
        send_cmd(8'd1);
        send_op(16'h0000, 16'h3F80);
        get_res("t6r", 16'h0000, 1'b1, cyc);
        chk("t6_starts", start_pulses - s0, 32'd1);
        chk("t6_idle", {31'b0, busy}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lmul_issue_ctrl.md
Name: lmul_issue_ctrl

Overview:
Initiator-side sequencer for the LSTM datapath's LMUL multiplier unit. It accepts a command giving the number of BF16 operand pairs to process and pulls that many pairs from an operand stream. For each pair it issues a start pulse to one LMUL unit, waits for the unit's result, and forwards the upper 16 bits as a BF16 product on a backpressured result stream. It also flags a timeout if the unit never responds.

Parameters:
LEN_W, 8, width of the command length field (max batch 2^LEN_W-1 pairs)
TIMEOUT, 15, cycles to wait for lmul_ready after a start before declaring a timeout
CNT_W, 4, width of the timeout counter (must hold TIMEOUT)

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command valid
cmd_ready  out  1  high only in IDLE
cmd_len  in  LEN_W  number of pairs in the batch; 0 is legal
op_valid  in  1  operand pair valid
op_ready  out  1  high only in FETCH
op_a  in  16  BF16 operand A
op_b  in  16  BF16 operand B
lmul_start  out  1  one-cycle start pulse to the LMUL unit
lmul_a  out  16  operand A to the unit, registered, held from start until the result is captured
lmul_b  out  16  operand B to the unit, same holding rule
lmul_ready  in  1  result-ready level from the unit
lmul_out  in  32  unit result; product in [31:16], [15:0] zero
res_valid  out  1  result valid
res_ready  in  1  result consumer ready
res_data  out  16  BF16 product, equal to lmul_out[31:16] at capture
res_last  out  1  high with the final result of a batch
busy  out  1  high in any state other than IDLE
err_timeout  out  1  sticky timeout flag; cleared only by reset or by acceptance of a new command

Behaviour:
- Reset values: cmd_ready=1, op_ready=0, lmul_start=0, lmul_a=0, lmul_b=0, res_valid=0, res_data=0, res_last=0, busy=0, err_timeout=0. Internal state: IDLE, remaining=0, timeout counter=0.
- Reset asserted mid-batch: return to IDLE immediately and drop all in-flight data. No further start is issued.
- IDLE:
  - On cmd_valid and cmd_ready, latch cmd_len into remaining and clear err_timeout.
  - If cmd_len==0, stay in IDLE and emit no result.
  - Otherwise go to FETCH.
- FETCH:
  - op_ready=1.
  - On op_valid&op_ready, register op_a/op_b into lmul_a/lmul_b and go to ISSUE.
- ISSUE (exactly 1 cycle):
  - lmul_start=1; lmul_ready is ignored this cycle because it is stale.
  - Load the timeout counter with TIMEOUT and go to WAIT.
- WAIT:
  - lmul_ready is sampled only from the cycle after ISSUE onward.
  - On lmul_ready=1, capture lmul_out[31:16] into res_data. Set res_last=(remaining==1), set res_valid=1, and go to EMIT.
  - Otherwise decrement the counter.
  - If the counter is 0 and lmul_ready=0: set err_timeout=1, set remaining=0, and go to IDLE with no result emitted.
- EMIT:
  - Hold res_valid, res_data and res_last stable until res_ready.
  - On res_valid&res_ready, deassert res_valid and res_last and decrement remaining.
  - If remaining becomes 0, go to IDLE; else go to FETCH.
- lmul_a/lmul_b change only on an operand handshake. The unit samples them in the ISSUE cycle.
- Throughput: one pair per (1 FETCH handshake + 1 ISSUE + unit latency + 1 EMIT handshake) cycles, minimum. With the unit's LATENCY=5, a result appears in res_data after 6 WAIT cycles with no stalls.
- No overlap: only one start is outstanding at any time.
- cmd_valid is ignored outside IDLE.
- lmul_ready seen high in FETCH or EMIT has no effect.

Test Plan:
- Reset, then cmd_len=1 with op_a=0x3F80, op_b=0x3F80 and res_ready=1 -> one lmul_start pulse; res_data=0x3F80 with res_last=1; busy returns to 0 one cycle after the handshake.
- cmd_len=3 with pairs (0x4000,0x4000), (0xBF80,0x4000), (0x0000,0x3F80) -> res_data sequence 0x4080, 0xC000, 0x0000; res_last high only on the third; exactly 3 start pulses.
- res_ready held low 10 cycles on the first result of a 2-pair batch -> res_data and res_valid stable for all 10 cycles; op_ready stays 0; no second start until the handshake completes.
- LMUL stub that never raises ready, TIMEOUT=15 -> err_timeout=1 after 15 WAIT cycles; state returns to IDLE; res_valid never asserted. A following cmd_len=1 clears err_timeout and completes normally.
- cmd_len=0 -> no op_ready, no lmul_start, no result; cmd_ready stays 1.
- Assert rst_n low during WAIT of pair 2 of 4 -> all outputs take their reset values asynchronously; after release, a fresh cmd_len=1 runs correctly.
